// File: rtl/tiny_soc_pkg.sv
// Shared types for the tiny SoC memory arbiter: bus word types, response-stage record
// and the strobe-to-bit-mask helper.
package tiny_soc_pkg;

  localparam int MaxReadLatency = 4;

  typedef logic [31:0] addr_t;
  typedef logic [31:0] data_t;
  typedef logic [3:0]  strb_t;
  typedef logic [2:0]  ch_id_t;

  typedef struct packed {
    logic   valid;
    ch_id_t ch;
    logic   we;
    logic   err;
    data_t  rdata;
  } rsp_stage_t;

  function automatic data_t expand_strb(input strb_t strb);
    data_t mask;
    for (int b = 0; b < 4; b++) mask[8*b +: 8] = {8{strb[b]}};
    return mask;
  endfunction

endpackage

// File: rtl/tiny_soc_rr_arb.sv
// Round-robin selector: grants the first requester at or after the pointer and then
// moves the pointer just past the winner.
module tiny_soc_rr_arb
  import tiny_soc_pkg::*;
#(
  parameter int NumCh = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [NumCh-1:0] req,
  output logic [NumCh-1:0] gnt,
  output ch_id_t           gnt_id,
  output logic             gnt_any
);

  ch_id_t ptr;

  always_comb begin
    int c;
    gnt     = '0;
    gnt_id  = '0;
    gnt_any = 1'b0;
    c       = 0;
    for (int off = 0; off < NumCh; off++) begin
      c = int'(ptr) + off;
      if (c >= NumCh) c = c - NumCh;
      if (en && !gnt_any && req[c]) begin
        gnt[c]  = 1'b1;
        gnt_id  = ch_id_t'(c);
        gnt_any = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (gnt_any) begin
      ptr <= (gnt_id == ch_id_t'(NumCh - 1)) ? '0 : gnt_id + 3'd1;
    end
  end

endmodule

// File: rtl/tiny_soc_mem_arb.sv
// Multi-channel SRAM arbiter with address relocation, range/alignment checks and a
// fixed-latency response pipeline. Optional stall injection: TINY_SOC_STALL_INJECT_EN.
module tiny_soc_mem_arb
  import tiny_soc_pkg::*;
#(
  parameter int          NumCh       = 2,
  parameter int          DepthWords  = 1 << 20,
  parameter int          ReadLatency = 1,
  parameter logic [31:0] RelocBase   = 32'h8000_0000,
  parameter logic [15:0] LfsrSeed    = 16'hACE1,
  localparam int         AW          = (DepthWords > 1) ? $clog2(DepthWords) : 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [NumCh-1:0]  ch_req_i,
  output logic [NumCh-1:0]  ch_gnt_o,
  input  logic [31:0]       ch_addr_i  [NumCh],
  input  logic [NumCh-1:0]  ch_we_i,
  input  logic [31:0]       ch_wdata_i [NumCh],
  input  logic [3:0]        ch_strb_i  [NumCh],
  output logic [NumCh-1:0]  ch_rvalid_o,
  output logic [31:0]       ch_rdata_o [NumCh],
  output logic [NumCh-1:0]  ch_err_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [AW-1:0]     mem_addr_o,
  output logic [31:0]       mem_wdata_o,
  output logic [31:0]       mem_wmask_o,
  input  logic [31:0]       mem_rdata_i
);

  logic       stall;
  logic       gnt_any;
  ch_id_t     gnt_id;
  addr_t      sel_addr, idx, word;
  data_t      sel_wdata, rd_capture, out_rdata;
  strb_t      sel_strb;
  logic       sel_we, acc_err;
  rsp_stage_t stage_in, last;
  rsp_stage_t stg [ReadLatency];

`ifdef TINY_SOC_STALL_INJECT_EN
  logic [15:0] lfsr;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) lfsr <= LfsrSeed;
    else       lfsr <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
  end

  assign stall = lfsr[0];
`else
  assign stall = 1'b0;
`endif

  tiny_soc_rr_arb #(.NumCh(NumCh)) u_arb (
    .clk     (clk_i),
    .rst     (rst_i),
    .en      (!rst_i && !stall),
    .req     (ch_req_i),
    .gnt     (ch_gnt_o),
    .gnt_id  (gnt_id),
    .gnt_any (gnt_any)
  );

  always_comb begin
    sel_addr  = '0;
    sel_we    = 1'b0;
    sel_wdata = '0;
    sel_strb  = '0;
    for (int i = 0; i < NumCh; i++) begin
      if (ch_gnt_o[i]) begin
        sel_addr  = ch_addr_i[i];
        sel_we    = ch_we_i[i];
        sel_wdata = ch_wdata_i[i];
        sel_strb  = ch_strb_i[i];
      end
    end
  end

  // The subtraction wraps, so addresses below the base become huge indices as well.
  assign idx     = sel_addr - RelocBase;
  assign word    = idx >> 2;
  assign acc_err = (sel_addr < RelocBase) || (word >= 32'(DepthWords)) || (sel_addr[1:0] != 2'b00);

  assign mem_req_o   = gnt_any && !acc_err;
  assign mem_we_o    = mem_req_o && sel_we;
  assign mem_addr_o  = mem_req_o ? word[AW-1:0] : '0;
  assign mem_wdata_o = mem_req_o ? sel_wdata : '0;
  assign mem_wmask_o = mem_req_o ? expand_strb(sel_strb) : '0;

  always_comb begin
    stage_in       = '0;
    stage_in.valid = gnt_any;
    stage_in.ch    = gnt_id;
    stage_in.we    = sel_we;
    stage_in.err   = gnt_any && acc_err;
  end

  assign rd_capture = (stg[0].valid && !stg[0].we && !stg[0].err) ? mem_rdata_i : '0;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < ReadLatency; i++) stg[i] <= '0;
    end else begin
      stg[0] <= stage_in;
      for (int i = 1; i < ReadLatency; i++) begin
        stg[i] <= stg[i-1];
        if (i == 1) stg[i].rdata <= rd_capture;
      end
    end
  end

  // With a single stage the SRAM data arrives in the response cycle and is passed through.
  assign last      = stg[ReadLatency-1];
  assign out_rdata = (ReadLatency == 1) ? rd_capture : last.rdata;

  always_comb begin
    ch_rvalid_o = '0;
    ch_err_o    = '0;
    for (int i = 0; i < NumCh; i++) begin
      ch_rdata_o[i] = '0;
      if (last.valid && last.ch == ch_id_t'(i)) begin
        ch_rvalid_o[i] = 1'b1;
        ch_err_o[i]    = last.err;
        ch_rdata_o[i]  = out_rdata;
      end
    end
  end

endmodule

// File: tb/tb_tiny_soc_mem_arb.sv
// Directed bench: instance A (3 ch, 16 words, latency 3) runs a vector table and the
// round-robin / stall sequences; instance B (2 ch, latency 4) covers mid-flight reset.
module tb_tiny_soc_mem_arb;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;

  // instance A
  logic        a_rst;
  logic [2:0]  a_req, a_gnt, a_we, a_rvalid, a_err;
  logic [31:0] a_addr [3];
  logic [31:0] a_wdata [3];
  logic [3:0]  a_strb [3];
  logic [31:0] a_rdata [3];
  logic        a_mreq, a_mwe;
  logic [3:0]  a_maddr;
  logic [31:0] a_mwdata, a_mwmask, a_mrdata;
  logic [31:0] a_mem [16];

  // instance B
  logic        b_rst;
  logic [1:0]  b_req, b_gnt, b_we, b_rvalid, b_err;
  logic [31:0] b_addr [2];
  logic [31:0] b_wdata [2];
  logic [3:0]  b_strb [2];
  logic [31:0] b_rdata [2];
  logic        b_mreq, b_mwe;
  logic [3:0]  b_maddr;
  logic [31:0] b_mwdata, b_mwmask, b_mrdata;
  logic [31:0] b_mem [16];

  tiny_soc_mem_arb #(.NumCh(3), .DepthWords(16), .ReadLatency(3)) dut_a (
    .clk_i(clk), .rst_i(a_rst), .ch_req_i(a_req), .ch_gnt_o(a_gnt),
    .ch_addr_i(a_addr), .ch_we_i(a_we), .ch_wdata_i(a_wdata), .ch_strb_i(a_strb),
    .ch_rvalid_o(a_rvalid), .ch_rdata_o(a_rdata), .ch_err_o(a_err),
    .mem_req_o(a_mreq), .mem_we_o(a_mwe), .mem_addr_o(a_maddr),
    .mem_wdata_o(a_mwdata), .mem_wmask_o(a_mwmask), .mem_rdata_i(a_mrdata)
  );

  tiny_soc_mem_arb #(.NumCh(2), .DepthWords(16), .ReadLatency(4)) dut_b (
    .clk_i(clk), .rst_i(b_rst), .ch_req_i(b_req), .ch_gnt_o(b_gnt),
    .ch_addr_i(b_addr), .ch_we_i(b_we), .ch_wdata_i(b_wdata), .ch_strb_i(b_strb),
    .ch_rvalid_o(b_rvalid), .ch_rdata_o(b_rdata), .ch_err_o(b_err),
    .mem_req_o(b_mreq), .mem_we_o(b_mwe), .mem_addr_o(b_maddr),
    .mem_wdata_o(b_mwdata), .mem_wmask_o(b_mwmask), .mem_rdata_i(b_mrdata)
  );

  // SRAM models: read data one cycle after the request
  always @(posedge clk) begin
    if (a_mreq) begin
      if (a_mwe) a_mem[a_maddr] <= (a_mem[a_maddr] & ~a_mwmask) | (a_mwdata & a_mwmask);
      a_mrdata <= a_mem[a_maddr];
    end
    if (b_mreq) begin
      if (b_mwe) b_mem[b_maddr] <= (b_mem[b_maddr] & ~b_mwmask) | (b_mwdata & b_mwmask);
      b_mrdata <= b_mem[b_maddr];
    end
  end

  logic [15:0] lfsr_m;
  always @(posedge clk or posedge a_rst) begin
    if (a_rst) lfsr_m <= 16'hACE1;
    else       lfsr_m <= {lfsr_m[0] ^ lfsr_m[2] ^ lfsr_m[3] ^ lfsr_m[5], lfsr_m[15:1]};
  end

  typedef struct {
    logic [1:0]  ch;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic        exp_req;
    logic [3:0]  exp_maddr;
    logic [31:0] exp_mask;
    logic        exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs [11];

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s[%0d]: got %h, want %h", nm, idx, act, exp);
    end
  endtask

  task automatic run_vec(input int k, input vec_t v);
    int n;
    logic [2:0] onehot;
    n = 0;
    onehot = 3'b001 << v.ch;
    @(negedge clk);
    a_addr[v.ch]  = v.addr;
    a_we          = '0;
    a_we[v.ch]    = v.we;
    a_wdata[v.ch] = v.wdata;
    a_strb[v.ch]  = v.strb;
    a_req         = onehot;
    #1;
    while (a_gnt == 3'b000 && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("gnt", k, 32'(a_gnt), 32'(onehot));
    chk("mem_req", k, 32'(a_mreq), 32'(v.exp_req));
    if (v.exp_req) begin
      chk("mem_addr", k, 32'(a_maddr), 32'(v.exp_maddr));
      chk("mem_wmask", k, a_mwmask, v.exp_mask);
      chk("mem_we", k, 32'(a_mwe), 32'(v.we));
    end
    @(posedge clk);
    #1 a_req = '0;
    @(posedge clk);
    #1 chk("rvalid_early", k, 32'(a_rvalid), 32'h0);
    chk("err_idle", k, 32'(a_err), 32'h0);
    @(posedge clk);
    #1 chk("rvalid", k, 32'(a_rvalid), 32'(onehot));
    chk("err", k, 32'(a_err), 32'(onehot & {3{v.exp_err}}));
    chk("rdata", k, a_rdata[v.ch], v.exp_rdata);
    @(posedge clk);
    #1 chk("rvalid_late", k, 32'(a_rvalid), 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    logic [1:0] seen;
    logic [2:0] rr_exp [4];

    for (int i = 0; i < 16; i++) begin
      a_mem[i] = '0;
      b_mem[i] = '0;
    end
    a_mrdata = '0; b_mrdata = '0;
    a_req = '0; a_we = '0; b_req = '0; b_we = '0;
    for (int i = 0; i < 3; i++) begin
      a_addr[i] = 32'h8000_0000; a_wdata[i] = '0; a_strb[i] = '0;
    end
    for (int i = 0; i < 2; i++) begin
      b_addr[i] = 32'h8000_0000; b_wdata[i] = '0; b_strb[i] = '0;
    end

    //             ch    we    addr          wdata         strb  req   maddr mask          err   rdata
    vecs[0]  = '{2'd0, 1'b1, 32'h80000010, 32'hDEADBEEF, 4'hF, 1'b1, 4'd4,  32'hFFFFFFFF, 1'b0, 32'h0};
    vecs[1]  = '{2'd0, 1'b0, 32'h80000010, 32'h0,        4'h0, 1'b1, 4'd4,  32'h0,        1'b0, 32'hDEADBEEF};
    vecs[2]  = '{2'd1, 1'b1, 32'h80000014, 32'h12345678, 4'h5, 1'b1, 4'd5,  32'h00FF00FF, 1'b0, 32'h0};
    vecs[3]  = '{2'd1, 1'b0, 32'h80000014, 32'h0,        4'h0, 1'b1, 4'd5,  32'h0,        1'b0, 32'h00340078};
    vecs[4]  = '{2'd2, 1'b1, 32'h8000003C, 32'hCAFEF00D, 4'hC, 1'b1, 4'd15, 32'hFFFF0000, 1'b0, 32'h0};
    vecs[5]  = '{2'd2, 1'b0, 32'h8000003C, 32'h0,        4'h0, 1'b1, 4'd15, 32'h0,        1'b0, 32'hCAFE0000};
    vecs[6]  = '{2'd2, 1'b0, 32'h7FFFFFFC, 32'h0,        4'h0, 1'b0, 4'd0,  32'h0,        1'b1, 32'h0};
    vecs[7]  = '{2'd0, 1'b0, 32'h80000002, 32'h0,        4'h0, 1'b0, 4'd0,  32'h0,        1'b1, 32'h0};
    vecs[8]  = '{2'd1, 1'b0, 32'h80000040, 32'h0,        4'h0, 1'b0, 4'd0,  32'h0,        1'b1, 32'h0};
    vecs[9]  = '{2'd0, 1'b1, 32'hFFFFFFFC, 32'h11111111, 4'hF, 1'b0, 4'd0,  32'h0,        1'b1, 32'h0};
    vecs[10] = '{2'd1, 1'b0, 32'h80000000, 32'h0,        4'h0, 1'b1, 4'd0,  32'h0,        1'b0, 32'h0};

    // reset with requests pending: everything must stay quiet
    a_rst = 1'b1; b_rst = 1'b1;
    a_req = 3'b111; b_req = 2'b11;
    #12;
    chk("rst_gnt_a", 0, 32'(a_gnt), 32'h0);
    chk("rst_mreq_a", 0, 32'(a_mreq), 32'h0);
    chk("rst_rvalid_a", 0, 32'(a_rvalid), 32'h0);
    chk("rst_gnt_b", 0, 32'(b_gnt), 32'h0);
    a_req = '0; b_req = '0;
    @(negedge clk);
    a_rst = 1'b0; b_rst = 1'b0;

    for (int k = 0; k < 11; k++) run_vec(k, vecs[k]);

    // all three channels requesting continuously after a fresh reset
    @(negedge clk);
    a_rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a_addr[i] = 32'h8000_0000; a_strb[i] = '0;
    end
    a_we = '0;
    a_req = 3'b111;
    @(negedge clk);
    a_rst = 1'b0;
`ifndef TINY_SOC_STALL_INJECT_EN
    rr_exp[0] = 3'b001; rr_exp[1] = 3'b010; rr_exp[2] = 3'b100; rr_exp[3] = 3'b001;
    for (int k = 0; k < 4; k++) begin
      #1 chk("rr_gnt", k, 32'(a_gnt), 32'(rr_exp[k]));
      @(negedge clk);
    end
`else
    for (int k = 0; k < 40; k++) begin
      #1 chk("stall_gnt", k, 32'(a_gnt != 3'b000), 32'(!lfsr_m[0]));
      @(negedge clk);
    end
`endif
    a_req = '0;
    repeat (6) @(negedge clk);
    #1 chk("drain_a", 0, 32'(a_rvalid), 32'h0);

    // instance B: grant on ch0 (pointer moves to 1), then reset while it is in flight
    @(negedge clk);
    b_we = '0;
    b_req = 2'b01;
    n = 0;
    #1;
    while (b_gnt == 2'b00 && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("b_gnt0", 0, 32'(b_gnt), 32'h1);
    @(posedge clk);
    #1 b_req = '0;
    @(negedge clk);
    b_rst = 1'b1;
    b_req = 2'b11;
    #1 chk("b_rst_gnt", 0, 32'(b_gnt), 32'h0);
    chk("b_rst_rvalid", 0, 32'(b_rvalid), 32'h0);
    b_req = '0;
    @(negedge clk);
    b_rst = 1'b0;
    seen = '0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      seen = seen | b_rvalid;
    end
    chk("b_no_rvalid", 0, 32'(seen), 32'h0);

    // pointer back at 0: both request, ch0 wins; then check the 4-cycle latency
    b_req = 2'b11;
    n = 0;
    #1;
    while (b_gnt == 2'b00 && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("b_ptr_gnt", 0, 32'(b_gnt), 32'h1);
    @(posedge clk);
    #1 b_req = '0;
    @(posedge clk);
    @(posedge clk);
    #1 chk("b_rvalid_early", 0, 32'(b_rvalid), 32'h0);
    @(posedge clk);
    #1 chk("b_rvalid", 0, 32'(b_rvalid), 32'h1);
    chk("b_err", 0, 32'(b_err), 32'h0);
    chk("b_rdata", 0, b_rdata[0], 32'h0);
    @(posedge clk);
    #1 chk("b_rvalid_late", 0, 32'(b_rvalid), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
